vga_capture: RTL

VGA sink for the 1024x768 mode. It samples HSYNC/VSYNC/R/G/B on the pixel clock and recovers the pixel position from the sync edges. It checks the line and frame geometry against the mode parameters and emits 8-bit pixels with X/Y coordinates once the timing is locked. It sits at the receive end of a VGA link, or in loopback opposite the team's timing generator for self-test.

---
 rtl/vga_capture_if.sv | 26 ++
 rtl/vga_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_capture_if.sv
// Signal bundle between a VGA source and vga_capture.
// The source drives sync and colour; the capture block returns the recovered pixel stream.
interface vga_capture_if;
  logic        HSYNC;
  logic        VSYNC;
  logic [2:0]  R;
  logic [2:0]  G;
  logic [1:0]  B;
  logic [7:0]  PIXEL_DATA;
  logic        PIXEL_VALID;
  logic [10:0] POS_X;
  logic [10:0] POS_Y;
  logic        FRAME_START;
  logic        LOCKED;
  logic        SYNC_ERR;

  modport master (
    output HSYNC, VSYNC, R, G, B,
    input  PIXEL_DATA, PIXEL_VALID, POS_X, POS_Y, FRAME_START, LOCKED, SYNC_ERR
  );

  modport slave (
    input  HSYNC, VSYNC, R, G, B,
    output PIXEL_DATA, PIXEL_VALID, POS_X, POS_Y, FRAME_START, LOCKED, SYNC_ERR
  );
endinterface

// File: rtl/vga_capture.sv
// VGA sink: recovers pixel position from the sync edges, verifies line and frame
// geometry against the mode, and emits coordinates once the timing is locked.
module vga_capture #(
  parameter int   SYNC_PULSE_HORIZONTAL   = 136,
  parameter int   BACK_PORCH_HORIZONTAL   = 144,
  parameter int   VISIBLE_AREA_HORIZONTAL = 1024,
  parameter int   WHOLE_LINE_HORIZONTAL   = 1328,
  parameter int   SYNC_PULSE_VERTICAL     = 6,
  parameter int   BACK_PORCH_VERTICAL     = 29,
  parameter int   VISIBLE_AREA_VERTICAL   = 768,
  parameter int   WHOLE_FRAME_VERTICAL    = 806,
  parameter logic SYNC_ACTIVE             = 1'b1
) (
  input  logic         VGACLK,
  input  logic         RST_IN,
  vga_capture_if.slave vga
);

  localparam logic [10:0] LP_HS         = 11'(SYNC_PULSE_HORIZONTAL + BACK_PORCH_HORIZONTAL);
  localparam logic [10:0] LP_HS_END     = 11'(SYNC_PULSE_HORIZONTAL + BACK_PORCH_HORIZONTAL + VISIBLE_AREA_HORIZONTAL);
  localparam logic [10:0] LP_VS         = 11'(SYNC_PULSE_VERTICAL + BACK_PORCH_VERTICAL);
  localparam logic [10:0] LP_VS_END     = 11'(SYNC_PULSE_VERTICAL + BACK_PORCH_VERTICAL + VISIBLE_AREA_VERTICAL);
  localparam logic [10:0] LP_LINE_LAST  = 11'(WHOLE_LINE_HORIZONTAL - 1);
  localparam logic [10:0] LP_FRAME_LAST = 11'(WHOLE_FRAME_VERTICAL - 1);
  localparam logic [10:0] LP_H_MAX      = 11'h7FF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic        r_hs1, r_vs1, r_hs1_d, r_vs1_d;
  logic [7:0]  r_rgb1;
  logic [10:0] r_h_cnt, r_v_cnt;
  logic        r_frame_pend, r_line_seen;
  state_t      r_state, w_next_state;

  logic [7:0]  r_pixel_data;
  logic        r_pixel_valid, r_frame_start, r_locked, r_sync_err;
  logic [10:0] r_pos_x, r_pos_y;

  logic        w_hs_rise, w_vs_rise, w_boundary, w_timeout;
  logic        w_line_err, w_frame_err, w_any_err, w_visible, w_valid;
  logic [10:0] w_cur_h, w_cur_v;

  // Input sampling stage plus previous-sample copies for edge detection
  always_ff @(posedge VGACLK or posedge RST_IN) begin
    if (RST_IN) begin
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_hs1_d <= 1'b0;
      r_vs1_d <= 1'b0;
      r_rgb1  <= 8'd0;
    end else begin
      r_hs1   <= vga.HSYNC;
      r_vs1   <= vga.VSYNC;
      r_hs1_d <= r_hs1;
      r_vs1_d <= r_vs1;
      r_rgb1  <= {vga.R, vga.G, vga.B};
    end
  end

  // Position recovery and geometry checks; v position is taken after the frame-boundary update
  always_comb begin
    w_hs_rise  = (r_hs1 == SYNC_ACTIVE) && (r_hs1_d != SYNC_ACTIVE);
    w_vs_rise  = (r_vs1 == SYNC_ACTIVE) && (r_vs1_d != SYNC_ACTIVE);
    w_boundary = w_hs_rise && (r_frame_pend || w_vs_rise);
    w_timeout  = !w_hs_rise && (r_h_cnt == LP_H_MAX);
    if (w_hs_rise) begin
      w_cur_h = 11'd0;
    end else if (r_h_cnt == LP_H_MAX) begin
      w_cur_h = LP_H_MAX;
    end else begin
      w_cur_h = r_h_cnt + 11'd1;
    end
    if (w_boundary) begin
      w_cur_v = 11'd0;
    end else if (w_hs_rise) begin
      w_cur_v = r_v_cnt + 11'd1;
    end else begin
      w_cur_v = r_v_cnt;
    end
    w_line_err  = w_hs_rise && r_line_seen && (r_h_cnt != LP_LINE_LAST);
    w_frame_err = w_boundary && (r_v_cnt != LP_FRAME_LAST);
    w_any_err   = w_line_err || w_frame_err || w_timeout;
    w_visible   = (w_cur_h >= LP_HS) && (w_cur_h < LP_HS_END) &&
                  (w_cur_v >= LP_VS) && (w_cur_v < LP_VS_END);
  end

  // Line/frame counters and pending-VSYNC bookkeeping
  always_ff @(posedge VGACLK or posedge RST_IN) begin
    if (RST_IN) begin
      r_h_cnt      <= 11'd0;
      r_v_cnt      <= 11'd0;
      r_frame_pend <= 1'b0;
      r_line_seen  <= 1'b0;
    end else begin
      r_h_cnt <= w_cur_h;
      r_v_cnt <= w_cur_v;
      if (w_boundary) begin
        r_frame_pend <= 1'b0;
      end else if (w_vs_rise) begin
        r_frame_pend <= 1'b1;
      end else begin
        r_frame_pend <= r_frame_pend;
      end
      if (w_timeout) begin
        r_line_seen <= 1'b0;
      end else if (w_hs_rise) begin
        r_line_seen <= 1'b1;
      end else begin
        r_line_seen <= r_line_seen;
      end
    end
  end

  // Lock state register
  always_ff @(posedge VGACLK or posedge RST_IN) begin
    if (RST_IN) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Lock transitions; a frame error while measuring restarts the measurement in place
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (w_boundary) w_next_state = ST_MEASURE;
        else            w_next_state = ST_SEARCH;
      end
      ST_MEASURE: begin
        if (w_line_err || w_timeout)       w_next_state = ST_SEARCH;
        else if (w_boundary && !w_frame_err) w_next_state = ST_LOCKED;
        else                                 w_next_state = ST_MEASURE;
      end
      ST_LOCKED: begin
        if (w_any_err) w_next_state = ST_SEARCH;
        else           w_next_state = ST_LOCKED;
      end
      default: w_next_state = ST_SEARCH;
    endcase
    w_valid = w_visible && (w_next_state == ST_LOCKED);
  end

  // Output register; validity follows the next state so it drops together with LOCKED
  always_ff @(posedge VGACLK or posedge RST_IN) begin
    if (RST_IN) begin
      r_pixel_data  <= 8'd0;
      r_pixel_valid <= 1'b0;
      r_pos_x       <= 11'd0;
      r_pos_y       <= 11'd0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_pixel_data  <= r_rgb1;
      r_pixel_valid <= w_valid;
      r_pos_x       <= w_valid ? (w_cur_h - LP_HS) : 11'd0;
      r_pos_y       <= w_valid ? (w_cur_v - LP_VS) : 11'd0;
      r_frame_start <= w_valid && (w_cur_h == LP_HS) && (w_cur_v == LP_VS);
      r_locked      <= (w_next_state == ST_LOCKED);
      r_sync_err    <= w_any_err && (r_state != ST_SEARCH);
    end
  end

  assign vga.PIXEL_DATA  = r_pixel_data;
  assign vga.PIXEL_VALID = r_pixel_valid;
  assign vga.POS_X       = r_pos_x;
  assign vga.POS_Y       = r_pos_y;
  assign vga.FRAME_START = r_frame_start;
  assign vga.LOCKED      = r_locked;
  assign vga.SYNC_ERR    = r_sync_err;

endmodule
